// File: rtl/fifo_stream_pkg.sv
// Shared constants for the FIFO-to-stream adapter: buffer depth, occupancy width, clog2 helper.
package fifo_stream_pkg;

  localparam int unsigned BUF_DEPTH = 2;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned v;
    int unsigned r;
    v = (n > 0) ? n - 1 : 0;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Occupancy must represent 0..BUF_DEPTH inclusive.
  localparam int unsigned OCC_W = clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry in-order buffer; head is a dedicated register so the stream data is registered.
module stream_skid_buf
  import fifo_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [OCC_W-1:0]      occ,
  output logic [DATA_WIDTH-1:0] head
);

  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;
  logic [OCC_W-1:0]      r_occ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else if (flush) begin
      r_occ <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (r_occ == '0) r_head <= din;
          else             r_tail <= din;
          r_occ <= r_occ + OCC_W'(1);
        end
        2'b01: begin
          // Head only moves when a second word is waiting, keeping m_data stable otherwise.
          if (r_occ == OCC_W'(BUF_DEPTH)) r_head <= r_tail;
          r_occ <= r_occ - OCC_W'(1);
        end
        2'b11: begin
          if (r_occ == OCC_W'(1)) begin
            r_head <= din;
          end else begin
            r_head <= r_tail;
            r_tail <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign occ  = r_occ;
  assign head = r_head;

endmodule

// File: rtl/fifo_stream_adapter.sv
// Drains a 1-cycle-latency synchronous FIFO into a valid/ready stream at full throughput.
// Optional m_last burst marking is enabled by defining BURST_LAST_EN.
module fifo_stream_adapter
  import fifo_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_r_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  localparam int unsigned SUM_W = OCC_W + 1;

  if (BURST_LEN == 0) begin : g_len_chk
    $error("BURST_LEN must be at least 1");
  end

  logic             r_inflight;
  logic [OCC_W-1:0] w_occ;
  logic             w_pop;
  logic             w_push;
  logic [SUM_W-1:0] w_need;

  assign w_pop  = m_valid & m_ready;
  assign w_push = r_inflight & ~flush;

  // Slots committed after this edge: buffered + returning word, less the one leaving.
  assign w_need    = SUM_W'(w_occ) + SUM_W'(r_inflight) - SUM_W'(w_pop);
  assign fifo_r_en = ~rst & ~fifo_empty & ~flush & (w_need < SUM_W'(BUF_DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_inflight <= 1'b0;
    else     r_inflight <= fifo_r_en;
  end

  stream_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .push (w_push),
    .pop  (w_pop),
    .din  (fifo_data),
    .occ  (w_occ),
    .head (m_data)
  );

  assign m_valid = (w_occ != '0);

`ifdef BURST_LAST_EN
  localparam int unsigned     CNT_W    = (BURST_LEN > 1) ? clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BURST_LEN - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_cnt <= '0;
    else if (flush) r_cnt <= '0;
    else if (w_pop) r_cnt <= (r_cnt == LAST_IDX) ? '0 : r_cnt + CNT_W'(1);
  end

  assign m_last = m_valid & (r_cnt == LAST_IDX);
`else
  assign m_last = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_stream_adapter.sv
// Bench for fifo_stream_adapter: FIFO model, in-order scoreboard and directed plus random traffic.
module tb_fifo_stream_adapter;

  localparam int unsigned DW = 8;
  localparam int unsigned BL = 4;
`ifdef BURST_LAST_EN
  localparam bit LAST_EN = 1'b1;
`else
  localparam bit LAST_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_r_en;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;

  fifo_stream_adapter #(
    .DATA_WIDTH(DW),
    .BURST_LEN (BL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_r_en (fifo_r_en),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Synchronous FIFO model: data appears the cycle after an accepted read.
  logic [DW-1:0] fifo_mem [1024];
  int            wr_idx = 0;
  int            rd_idx = 0;
  assign fifo_empty = (rd_idx == wr_idx);

  always @(posedge clk) begin
    if (!rst && fifo_r_en) begin
      fifo_data <= fifo_mem[rd_idx];
      rd_idx    <= rd_idx + 1;
    end
  end

  task automatic fifo_push(input logic [DW-1:0] d);
    fifo_mem[wr_idx] = d;
    wr_idx = wr_idx + 1;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard: words read from the FIFO must come out in order unless discarded by flush.
  logic [DW-1:0] read_q [$];
  int            n_beats = 0;
  int            n_reads = 0;
  int            n_lasts = 0;
  int            burst_pos = 0;
  logic [DW-1:0] last_beat = '0;
  logic [DW-1:0] prev_data = '0;
  bit            prev_stall = 1'b0;
  bit            seen33 = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      read_q.delete();
      burst_pos  = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("hold_valid", 32'(m_valid), 32'd1);
        check_eq("hold_data", 32'(m_data), 32'(prev_data));
      end
      if (fifo_r_en) begin
        check_eq("rd_on_empty", 32'(fifo_empty), 32'd0);
        n_reads++;
      end
      check_eq("m_last", 32'(m_last),
               32'(LAST_EN && m_valid && (burst_pos == int'(BL) - 1)));
      if (flush) begin
        read_q.delete();
        burst_pos = 0;
      end else begin
        if (m_valid && m_ready) begin
          check_eq("beat_has_src", 32'(read_q.size() != 0), 32'd1);
          if (read_q.size() != 0) check_eq("beat_data", 32'(m_data), 32'(read_q.pop_front()));
          last_beat = m_data;
          n_beats++;
          if (m_last) n_lasts++;
          if (m_data == 8'h33) seen33 = 1'b1;
          burst_pos = (burst_pos + 1) % int'(BL);
        end
        if (fifo_r_en) read_q.push_back(fifo_mem[rd_idx]);
      end
      prev_stall = m_valid && !m_ready && !flush;
      prev_data  = m_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  int b0, r0, l0;

  initial begin
    rst = 1'b1; flush = 1'b0; m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) fifo_push(8'(i));

    // reset with a non-empty FIFO
    repeat (2) @(negedge clk);
    check_eq("rst_r_en", 32'(fifo_r_en), 32'd0);
    check_eq("rst_valid", 32'(m_valid), 32'd0);
    check_eq("rst_data", 32'(m_data), 32'd0);
    check_eq("rst_last", 32'(m_last), 32'd0);

    // streaming: first word two edges after release, then one per cycle
    @(posedge clk); #1;
    rst = 1'b0; m_ready = 1'b1;
    @(negedge clk); check_eq("lat_e0_valid", 32'(m_valid), 32'd0);
    @(negedge clk); check_eq("lat_e1_valid", 32'(m_valid), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check_eq("stream_valid", 32'(m_valid), 32'd1);
      check_eq("stream_data", 32'(m_data), 32'(i));
    end

    // backpressure mid-stream
    step(1);
    for (int i = 0; i < 10; i++) fifo_push(8'(8'h10 + i));
    step(3);
    m_ready = 1'b0;
    step(5);
    check_eq("bp_occ", 32'(dut.w_occ), 32'd2);
    check_eq("bp_r_en", 32'(fifo_r_en), 32'd0);
    check_eq("bp_valid", 32'(m_valid), 32'd1);
    m_ready = 1'b1;
    step(20);
    check_eq("bp_beats", 32'(n_beats), 32'd18);

    // single-word FIFO
    r0 = n_reads; b0 = n_beats;
    fifo_push(8'hA5);
    step(8);
    check_eq("one_reads", 32'(n_reads - r0), 32'd1);
    check_eq("one_beats", 32'(n_beats - b0), 32'd1);
    check_eq("one_data", 32'(last_beat), 32'hA5);
    check_eq("one_idle", 32'(m_valid), 32'd0);

    // flush while a read is in flight
    m_ready = 1'b0;
    fifo_push(8'h31); fifo_push(8'h32);
    step(4);
    check_eq("fl_occ", 32'(dut.w_occ), 32'd2);
    check_eq("fl_head", 32'(m_data), 32'h31);
    fifo_push(8'h33);
    m_ready = 1'b1;
    step(1);
    m_ready = 1'b0; flush = 1'b1;
    fifo_push(8'h34);
    check_eq("fl_inflight", 32'(dut.r_inflight), 32'd1);
    check_eq("fl_r_en", 32'(fifo_r_en), 32'd0);
    step(1);
    flush = 1'b0;
    check_eq("fl_valid", 32'(m_valid), 32'd0);
    b0 = n_beats;
    m_ready = 1'b1;
    step(6);
    check_eq("fl_beats", 32'(n_beats - b0), 32'd1);
    check_eq("fl_resume", 32'(last_beat), 32'h34);
    check_eq("fl_no33", 32'(seen33), 32'd0);

    // burst marking over 8 words with random backpressure
    flush = 1'b1; step(1); flush = 1'b0;
    b0 = n_beats; l0 = n_lasts;
    for (int i = 0; i < 8; i++) fifo_push(8'($urandom));
    for (int i = 0; i < 200 && (n_beats - b0) < 8; i++) begin
      m_ready = 1'($urandom % 2);
      step(1);
    end
    m_ready = 1'b0;
    check_eq("burst_beats", 32'(n_beats - b0), 32'd8);
    check_eq("burst_lasts", 32'(n_lasts - l0), LAST_EN ? 32'd2 : 32'd0);

    // random traffic with occasional flush
    for (int i = 0; i < 400; i++) begin
      if ($urandom % 2 == 0) fifo_push(8'($urandom));
      m_ready = ($urandom % 4) != 0;
      flush   = ($urandom % 50) == 0;
      step(1);
    end
    flush = 1'b0; m_ready = 1'b1;
    step(30);
    check_eq("rand_idle", 32'(m_valid), 32'd0);
    check_eq("rand_drained", 32'(read_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
